int2float_share_arb: RTL and testbench

- Sequencer/arbiter that shares one combinational 11-bit-integer-to-7-bit-float converter among NUM_REQ requesters.
- Accepts requests over per-requester valid/ready and grants them round-robin.
- Holds the operand stable on the converter input for a full cycle, captures the result, and returns it with the requester ID on one response channel with backpressure.
- Sits between the converter (instantiated alongside, wired through conv_a/conv_y) and the client blocks.

---
 rtl/int2float_share_arb.sv | 120 ++++++++++++
 tb/tb_int2float_share_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/int2float_share_arb.sv
// Round-robin arbiter sharing one int-to-float converter among NUM_REQ clients.
// Optional macro INT2FLOAT_SHARE_ARB_ZERO_BYPASS_EN: zero operands skip the converter.
module int2float_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         conv_a,
    input  logic [OUT_W-1:0]        conv_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        RESP
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] nxt_ptr;
    logic [ID_W-1:0] id_reg;
    logic [IN_W-1:0] win_data;
    logic            any_v;
    logic            grant;
    logic            bypass;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        any_v    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_v && req_valid[idx]) begin
                any_v    = 1'b1;
                win      = ID_W'(idx);
                win_data = req_data[idx*IN_W +: IN_W];
            end
        end
    end

    // Grants happen only when the output slot is free or being freed.
    assign grant = any_v & ~rst &
                   ((state == IDLE) | ((state == RESP) & rsp_ready));

    assign nxt_ptr = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

`ifdef INT2FLOAT_SHARE_ARB_ZERO_BYPASS_EN
    assign bypass = (win_data == '0);
`else
    assign bypass = 1'b0;
`endif

    // One-hot ready toward the winner in grant cycles only.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant & (win == ID_W'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (grant) nxt = bypass ? RESP : CONV;
            CONV: nxt = RESP;
            RESP: if (rsp_ready) nxt = grant ? (bypass ? RESP : CONV) : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand launch on grant, result capture after the converter settles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            id_reg   <= '0;
            conv_a   <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (grant) begin
            rr_ptr <= nxt_ptr;
            id_reg <= win;
            if (bypass) begin
                rsp_data <= '0;
                rsp_id   <= win;
            end else begin
                conv_a <= win_data;
            end
        end else if (state == CONV) begin
            rsp_data <= conv_y;
            rsp_id   <= id_reg;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_int2float_share_arb.sv
// Directed bench for int2float_share_arb with a bit-slice converter model.
// Honors INT2FLOAT_SHARE_ARB_ZERO_BYPASS_EN for the zero-operand sequence.
module tb_int2float_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [43:0] req_data;
    logic [3:0]  req_ready;
    logic [10:0] conv_a;
    logic [6:0]  conv_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [6:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int2float_share_arb #(
        .NUM_REQ(4), .ID_W(2), .IN_W(11), .OUT_W(7)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready),
        .conv_a(conv_a), .conv_y(conv_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign conv_y = conv_a[10:4];

    typedef struct {
        logic [3:0]  v;
        logic [43:0] d;
        logic        rr;
        logic [3:0]  e_rdy;
        logic        e_rv;
        logic [6:0]  e_data;
        logic [1:0]  e_id;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    localparam logic [43:0] D_ALL = {11'h030, 11'h020, 11'h010, 11'h000};
    localparam logic [43:0] D_ONE = {11'h000, 11'h3F0, 11'h000, 11'h000};
    localparam logic [43:0] D_BP  = {11'h070, 11'h050, 11'h060, 11'h000};
    localparam logic [43:0] D_Z1  = {11'h000, 11'h000, 11'h2A0, 11'h000};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [43:0] d,
                                input logic rr, input logic [3:0] e_rdy,
                                input logic e_rv, input logic [6:0] e_data,
                                input logic [1:0] e_id, input logic e_busy);
        vec_t r;
        r.v = v; r.d = d; r.rr = rr; r.e_rdy = e_rdy;
        r.e_rv = e_rv; r.e_data = e_data; r.e_id = e_id; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic step(input logic [3:0] v, input logic [43:0] d,
                        input logic rr);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;

        // All requesters valid from pointer 0: grants 0,1,2,3,0.
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0001, 0, 7'h0, 2'd0, 0));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0010, 1, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0100, 1, 7'h1, 2'd1, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b1000, 1, 7'h2, 2'd2, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'hF, D_ALL, 1, 4'b0001, 1, 7'h3, 2'd3, 1));
        tbl.push_back(mk(4'h0, D_ALL, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'h0, D_ALL, 1, 4'b0000, 1, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'h0, D_ALL, 1, 4'b0000, 0, 7'h0, 2'd0, 0));
        // Single request on 2 with pointer at 1.
        tbl.push_back(mk(4'b0100, D_ONE, 1, 4'b0100, 0, 7'h0, 2'd0, 0));
        tbl.push_back(mk(4'b0000, D_ONE, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'b0000, D_ONE, 1, 4'b0000, 1, 7'h3F, 2'd2, 1));
        tbl.push_back(mk(4'b0000, D_ONE, 1, 4'b0000, 0, 7'h0, 2'd0, 0));
        // Grant 2, then hold response 5 cycles with 1 and 3 waiting.
        tbl.push_back(mk(4'b0100, D_BP, 0, 4'b0100, 0, 7'h0, 2'd0, 0));
        tbl.push_back(mk(4'b1010, D_BP, 0, 4'b0000, 0, 7'h0, 2'd0, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'b1010, D_BP, 0, 4'b0000, 1, 7'h5, 2'd2, 1));
        tbl.push_back(mk(4'b1010, D_BP, 1, 4'b1000, 1, 7'h5, 2'd2, 1));
        tbl.push_back(mk(4'b0010, D_BP, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'b0010, D_BP, 1, 4'b0010, 1, 7'h7, 2'd3, 1));
        tbl.push_back(mk(4'b0000, D_BP, 1, 4'b0000, 0, 7'h0, 2'd0, 1));
        tbl.push_back(mk(4'b0000, D_BP, 1, 4'b0000, 1, 7'h6, 2'd1, 1));
        tbl.push_back(mk(4'b0000, D_BP, 1, 4'b0000, 0, 7'h0, 2'd0, 0));

        // Reset then idle.
        @(negedge clk);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst conv_a", conv_a, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'h0, '0, 1'b1);
            chk($sformatf("idle%0d rv", i), rsp_valid, 0);
            chk($sformatf("idle%0d busy", i), busy, 0);
            chk($sformatf("idle%0d rdy", i), req_ready, 0);
            chk($sformatf("idle%0d conv_a", i), conv_a, 0);
        end

        // Table-driven cycles.
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].rr);
            chk($sformatf("row%0d rdy", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d rv", i), rsp_valid, tbl[i].e_rv);
            chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_rv) begin
                chk($sformatf("row%0d data", i), rsp_data, tbl[i].e_data);
                chk($sformatf("row%0d id", i), rsp_id, tbl[i].e_id);
            end
        end

        // Reset while in CONV; pointer (now 2) must return to 0.
        step(4'hF, D_ALL, 1'b1);
        chk("rc grant", req_ready, 4'b0100);
        step(4'hF, D_ALL, 1'b1);
        chk("rc busy pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("rc busy async", busy, 0);
        chk("rc rv async", rsp_valid, 0);
        chk("rc conv_a", conv_a, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rc first grant", req_ready, 4'b0001);
        step(4'h0, D_ALL, 1'b0);
        step(4'h0, D_ALL, 1'b0);
        chk("rr rv pre", rsp_valid, 1);
        chk("rr id pre", rsp_id, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rr rv async", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Zero operand after a nonzero launch leaves conv_a at 2A0.
        step(4'b0010, D_Z1, 1'b1);
        chk("z grant1", req_ready, 4'b0010);
        step(4'b0000, D_Z1, 1'b1);
        step(4'b0000, D_Z1, 1'b1);
        chk("z data1", rsp_data, 7'h2A);
        chk("z id1", rsp_id, 1);
        step(4'b0001, '0, 1'b1);
        chk("z grant0", req_ready, 4'b0001);
`ifdef INT2FLOAT_SHARE_ARB_ZERO_BYPASS_EN
        step(4'b0000, '0, 1'b1);
        chk("z rv n1", rsp_valid, 1);
        chk("z data n1", rsp_data, 0);
        chk("z id n1", rsp_id, 0);
        chk("z conv_a held", conv_a, 11'h2A0);
        step(4'b0000, '0, 1'b1);
        chk("z idle", busy, 0);
`else
        step(4'b0000, '0, 1'b1);
        chk("z rv n1", rsp_valid, 0);
        chk("z conv_a", conv_a, 0);
        step(4'b0000, '0, 1'b1);
        chk("z rv n2", rsp_valid, 1);
        chk("z data n2", rsp_data, 0);
        chk("z id n2", rsp_id, 0);
        step(4'b0000, '0, 1'b1);
        chk("z idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
